// File: rtl/fifo_spi_drain.sv
// fifo_spi_drain
// Pops one word per frame from an upstream FIFO (1-cycle read latency) and
// shifts it out MSB-first on a 3-wire SPI-style master link. A FIFO error
// flag seen during the load cycle sets a sticky underrun flag and aborts the
// frame before cs_n ever drops. Completed frames are counted in words_sent_o.
//
// Optional feature macro: FIFO_SPI_DRAIN_PARITY_EN
//   defined   -> an even-parity bit (XOR of the word) follows the LSB as one
//                extra sclk cycle.
//   undefined -> frames are exactly DATA_W bits and no parity logic exists.
//
// Ports:
//   clk_i          system clock, rising edge
//   reset_i        asynchronous active-high reset
//   enable_i       permits new frames (looked at only while idle)
//   fifo_empty_i   FIFO empty flag
//   fifo_data_i    FIFO read data, valid the cycle after fifo_rd_en_o
//   fifo_err_i     FIFO error flag (read-on-empty)
//   clr_err_i      synchronous clear of underrun_o
//   fifo_rd_en_o   FIFO read strobe, one clk per word
//   sclk_o         serial clock, idles low
//   sdo_o          serial data, MSB first, changes when sclk falls
//   cs_n_o         frame select, active low
//   busy_o         high whenever not idle
//   done_o         one-clk pulse at the end of each completed frame
//   underrun_o     sticky read-on-empty error
//   words_sent_o   completed frame counter, wraps
module fifo_spi_drain #(
  parameter int DATA_W  = 24,
  parameter int CLK_DIV = 4,
  parameter int GAP_CYC = 2,
  parameter int CNT_W   = 16
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              enable_i,
  input  logic              fifo_empty_i,
  input  logic [DATA_W-1:0] fifo_data_i,
  input  logic              fifo_err_i,
  input  logic              clr_err_i,
  output logic              fifo_rd_en_o,
  output logic              sclk_o,
  output logic              sdo_o,
  output logic              cs_n_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              underrun_o,
  output logic [CNT_W-1:0]  words_sent_o
);

`ifdef FIFO_SPI_DRAIN_PARITY_EN
  localparam int FRAME_BITS = DATA_W + 1;
`else
  localparam int FRAME_BITS = DATA_W;
`endif
  localparam int BIT_W = $clog2(FRAME_BITS + 1);
  localparam int DIV_W = $clog2(CLK_DIV + 1);
  localparam int GAP_W = $clog2(GAP_CYC + 1);

  typedef enum logic [2:0] {IDLE, POP, LOAD, SHIFT, GAP} state_t;

  state_t                state_q, state_d;
  logic [FRAME_BITS-1:0] shift_q, shift_d;
  logic [BIT_W-1:0]      bit_q, bit_d;
  logic [DIV_W-1:0]      div_q, div_d;
  logic [GAP_W-1:0]      gap_q, gap_d;
  logic                  sclk_q, sclk_d;
  logic                  sdo_q, sdo_d;
  logic                  cs_n_q, cs_n_d;
  logic                  done_q, done_d;
  logic                  underrun_q, underrun_d;
  logic [CNT_W-1:0]      words_q, words_d;

  // State and registered outputs. Reset drops cs_n and sclk to their idle
  // levels immediately, which discards any word in flight.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      bit_q      <= '0;
      div_q      <= '0;
      gap_q      <= '0;
      sclk_q     <= 1'b0;
      sdo_q      <= 1'b0;
      cs_n_q     <= 1'b1;
      done_q     <= 1'b0;
      underrun_q <= 1'b0;
      words_q    <= '0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_q      <= bit_d;
      div_q      <= div_d;
      gap_q      <= gap_d;
      sclk_q     <= sclk_d;
      sdo_q      <= sdo_d;
      cs_n_q     <= cs_n_d;
      done_q     <= done_d;
      underrun_q <= underrun_d;
      words_q    <= words_d;
    end
  end

  // Next-state logic for the FSM and the serialiser datapath.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_d      = bit_q;
    div_d      = div_q;
    gap_d      = gap_q;
    sclk_d     = sclk_q;
    sdo_d      = sdo_q;
    cs_n_d     = cs_n_q;
    done_d     = 1'b0;
    words_d    = words_q;
    underrun_d = underrun_q;

    // Clear first so that a same-cycle set from LOAD below takes priority.
    if (clr_err_i) underrun_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (enable_i && !fifo_empty_i) state_d = POP;
      end
      POP: begin
        state_d = LOAD;
      end
      LOAD: begin
        // FIFO data and err are both valid here, one cycle after the read.
        if (fifo_err_i) begin
          underrun_d = 1'b1;
          state_d    = IDLE;
        end else begin
`ifdef FIFO_SPI_DRAIN_PARITY_EN
          shift_d = {fifo_data_i, ^fifo_data_i};
`else
          shift_d = fifo_data_i;
`endif
          sdo_d   = fifo_data_i[DATA_W-1];
          cs_n_d  = 1'b0;
          sclk_d  = 1'b0;
          bit_d   = '0;
          div_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (div_q == DIV_W'(CLK_DIV - 1)) begin
          div_d = '0;
          if (!sclk_q) begin
            sclk_d = 1'b1;
          end else begin
            sclk_d = 1'b0;
            if (bit_q == BIT_W'(FRAME_BITS - 1)) begin
              cs_n_d  = 1'b1;
              sdo_d   = 1'b0;
              done_d  = 1'b1;
              words_d = words_q + CNT_W'(1);
              gap_d   = '0;
              state_d = GAP;
            end else begin
              // Rotate rather than shift so the register stays fully used;
              // the wrapped MSB is never transmitted.
              bit_d   = bit_q + BIT_W'(1);
              shift_d = {shift_q[FRAME_BITS-2:0], shift_q[FRAME_BITS-1]};
              sdo_d   = shift_q[FRAME_BITS-2];
            end
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      GAP: begin
        if (gap_q == GAP_W'(GAP_CYC - 1)) state_d = IDLE;
        else gap_d = gap_q + GAP_W'(1);
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign fifo_rd_en_o = (state_q == POP);
  assign busy_o       = (state_q != IDLE);
  assign sclk_o       = sclk_q;
  assign sdo_o        = sdo_q;
  assign cs_n_o       = cs_n_q;
  assign done_o       = done_q;
  assign underrun_o   = underrun_q;
  assign words_sent_o = words_q;

endmodule

// File: tb/tb_fifo_spi_drain.sv
// tb_fifo_spi_drain
// Drives fifo_spi_drain from a small FIFO model and checks every frame on the
// serial link against a scoreboard of expected words. A monitor reconstructs
// frames from sclk/sdo/cs_n and compares bits, cs_n timing, done and the
// word counter. Define FIFO_SPI_DRAIN_PARITY_EN to exercise the parity build.
module tb_fifo_spi_drain;

  localparam int DATA_W  = 24;
  localparam int CLK_DIV = 2;
  localparam int GAP_CYC = 2;
  localparam int CNT_W   = 16;
`ifdef FIFO_SPI_DRAIN_PARITY_EN
  localparam int FRAME_BITS = DATA_W + 1;
`else
  localparam int FRAME_BITS = DATA_W;
`endif

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              enable = 1'b0;
  logic              fifoEmpty;
  logic [DATA_W-1:0] fifoData = '0;
  logic              fifoErr = 1'b0;
  logic              clrErr = 1'b0;
  logic              errInject = 1'b0;
  logic              fifoRdEn, sclk, sdo, csN, busy, done, underrun;
  logic [CNT_W-1:0]  wordsSent;

  typedef struct {
    logic [FRAME_BITS-1:0] bits;
    int                    gap;
  } exp_t;

  exp_t              expQ[$];
  logic [DATA_W-1:0] fifoMem [0:63];
  int                wrPtr = 0;
  int                rdPtr = 0;

  int vectorsApplied = 0;
  int miscompares    = 0;

  // monitor state
  logic                  prevCsN = 1'b1;
  logic                  prevSclk = 1'b0;
  logic                  prevRdEn = 1'b0;
  logic [FRAME_BITS-1:0] capBits = '0;
  int                    capCount = 0;
  int                    lowCnt = 0;
  int                    highCnt = 0;
  int                    framesDone = 0;
  int                    donePulses = 0;
  int                    rdEnCount = 0;
  int                    expWords = 0;

  fifo_spi_drain #(
    .DATA_W (DATA_W),
    .CLK_DIV(CLK_DIV),
    .GAP_CYC(GAP_CYC),
    .CNT_W  (CNT_W)
  ) dut (
    .clk_i       (clk),
    .reset_i     (reset),
    .enable_i    (enable),
    .fifo_empty_i(fifoEmpty),
    .fifo_data_i (fifoData),
    .fifo_err_i  (fifoErr),
    .clr_err_i   (clrErr),
    .fifo_rd_en_o(fifoRdEn),
    .sclk_o      (sclk),
    .sdo_o       (sdo),
    .cs_n_o      (csN),
    .busy_o      (busy),
    .done_o      (done),
    .underrun_o  (underrun),
    .words_sent_o(wordsSent)
  );

  always #5 clk = ~clk;

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectorsApplied++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // FIFO model: one-cycle read latency, err pulse on a read when requested.
  assign fifoEmpty = (rdPtr == wrPtr);

  always @(posedge clk) begin
    if (reset) begin
      rdPtr   <= wrPtr;
      fifoErr <= 1'b0;
    end else if (fifoRdEn) begin
      fifoErr <= errInject;
      if (rdPtr != wrPtr) begin
        fifoData <= fifoMem[rdPtr % 64];
        rdPtr    <= rdPtr + 1;
      end
    end else begin
      fifoErr <= 1'b0;
    end
  end

  // Queue a word in the FIFO and, if it should reach the wire, its expected
  // frame in the scoreboard. gap=0 means the preceding cs_n-high time is not
  // checked.
  task automatic applyStimulus(input logic [DATA_W-1:0] w, input bit expectFrame,
                               input int gap);
    exp_t e;
    fifoMem[wrPtr % 64] = w;
    wrPtr = wrPtr + 1;
    if (expectFrame) begin
`ifdef FIFO_SPI_DRAIN_PARITY_EN
      e.bits = {w, ^w};
`else
      e.bits = w;
`endif
      e.gap = gap;
      expQ.push_back(e);
    end
  endtask

  task automatic doReset();
    enable    = 1'b0;
    clrErr    = 1'b0;
    errInject = 1'b0;
    reset     = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic waitFrames(input int target, input int budget);
    int n = 0;
    while (framesDone < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput("frameCountInTime", framesDone, target);
  endtask

  // Monitor: samples on the falling clk edge, away from DUT updates.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      prevCsN    = 1'b1;
      prevSclk   = 1'b0;
      prevRdEn   = 1'b0;
      capCount   = 0;
      lowCnt     = 0;
      highCnt    = 0;
      framesDone = 0;
      donePulses = 0;
      rdEnCount  = 0;
      expWords   = 0;
    end else begin
      if (fifoRdEn) begin
        rdEnCount++;
        checkOutput("rdEnSingleCycle", prevRdEn, 1'b0);
      end
      if (done) donePulses++;
      if (!csN) begin
        if (prevCsN) begin
          capCount = 0;
          capBits  = '0;
          lowCnt   = 0;
          if (expQ.size() > 0 && expQ[0].gap != 0)
            checkOutput("csHighBetweenFrames", highCnt, expQ[0].gap);
        end
        lowCnt++;
        if (sclk && !prevSclk) begin
          capBits = {capBits[FRAME_BITS-2:0], sdo};
          capCount++;
        end
      end else if (!prevCsN) begin
        framesDone++;
        expWords++;
        checkOutput("doneAtFrameEnd", done, 1'b1);
        checkOutput("wordsSent", wordsSent, expWords);
        checkOutput("csLowClks", lowCnt, FRAME_BITS * 2 * CLK_DIV);
        checkOutput("bitCount", capCount, FRAME_BITS);
        if (expQ.size() == 0) begin
          vectorsApplied++;
          miscompares++;
          $display("[TB] FAIL unexpectedFrame: got bits 0x%0h, expected no frame", capBits);
        end else begin
          e = expQ.pop_front();
          checkOutput("frameBits", capBits, e.bits);
        end
        highCnt = 1;
      end else begin
        highCnt++;
      end
      prevCsN  = csN;
      prevSclk = sclk;
      prevRdEn = fifoRdEn;
    end
  end

  initial begin
    int n;

    // 1: reset values, nothing popped from an empty FIFO
    $display("[TB] test 1: reset and idle with empty FIFO");
    doReset();
    enable = 1'b1;
    #1;
    checkOutput("rstCsN", csN, 1'b1);
    checkOutput("rstSclk", sclk, 1'b0);
    checkOutput("rstSdo", sdo, 1'b0);
    checkOutput("rstBusy", busy, 1'b0);
    checkOutput("rstDone", done, 1'b0);
    checkOutput("rstUnderrun", underrun, 1'b0);
    checkOutput("rstWords", wordsSent, 0);
    checkOutput("rstRdEn", fifoRdEn, 1'b0);
    repeat (100) @(negedge clk);
    checkOutput("idleRdEnCount", rdEnCount, 0);
    checkOutput("idleBusy", busy, 1'b0);

    // 2: one word
    $display("[TB] test 2: single word 0xA5C3F0");
    doReset();
    enable = 1'b1;
    applyStimulus(24'hA5C3F0, 1'b1, 0);
    repeat (10) @(negedge clk);
    checkOutput("busyMidFrame", busy, 1'b1);
    checkOutput("csLowMidFrame", csN, 1'b0);
    waitFrames(1, 400);
    repeat (3) @(negedge clk);
    checkOutput("singleRdEn", rdEnCount, 1);
    checkOutput("singleDone", donePulses, 1);
    checkOutput("singleWords", wordsSent, 1);
    checkOutput("singleIdle", busy, 1'b0);

    // 3: three back-to-back words
    $display("[TB] test 3: three queued words");
    doReset();
    enable = 1'b1;
    applyStimulus(24'h000001, 1'b1, 0);
    applyStimulus(24'h800000, 1'b1, GAP_CYC + 3);
    applyStimulus(24'hFFFFFF, 1'b1, GAP_CYC + 3);
    waitFrames(3, 1200);
    repeat (3) @(negedge clk);
    checkOutput("tripleWords", wordsSent, 3);
    checkOutput("tripleRdEn", rdEnCount, 3);

    // 4: underrun on FIFO err, clear, then recovery
    $display("[TB] test 4: underrun and clear");
    doReset();
    enable    = 1'b1;
    errInject = 1'b1;
    applyStimulus(24'h0BAD00, 1'b0, 0);
    repeat (10) @(negedge clk);
    errInject = 1'b0;
    checkOutput("underrunSet", underrun, 1'b1);
    checkOutput("underrunCsN", csN, 1'b1);
    checkOutput("underrunWords", wordsSent, 0);
    checkOutput("underrunFrames", framesDone, 0);
    clrErr = 1'b1;
    @(negedge clk);
    clrErr = 1'b0;
    checkOutput("underrunCleared", underrun, 1'b0);
    applyStimulus(24'h3C5A69, 1'b1, 0);
    waitFrames(1, 400);
    checkOutput("recoveryUnderrun", underrun, 1'b0);

    // 5: reset mid-frame, then a fresh frame
    $display("[TB] test 5: reset during a frame");
    doReset();
    enable = 1'b1;
    applyStimulus(24'h123456, 1'b0, 0);
    n = 0;
    while (capCount < 10 && n < 400) begin
      @(negedge clk);
      n++;
    end
    checkOutput("tenBitsReached", capCount, 10);
    checkOutput("csLowBeforeReset", csN, 1'b0);
    #1 reset = 1'b1;
    #1;
    checkOutput("asyncCsN", csN, 1'b1);
    checkOutput("asyncSclk", sclk, 1'b0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    applyStimulus(24'h654321, 1'b1, 0);
    waitFrames(1, 400);
    checkOutput("afterResetWords", wordsSent, 1);

    // 6: word with odd weight (parity bit 1 in the parity build)
    $display("[TB] test 6: word 0x000007");
    doReset();
    enable = 1'b1;
    applyStimulus(24'h000007, 1'b1, 0);
    waitFrames(1, 400);
    repeat (3) @(negedge clk);
    checkOutput("finalScoreboardEmpty", expQ.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
    $finish;
  end

endmodule

// File: doc/fifo_spi_drain.md
Name: fifo_spi_drain

Overview:
Downstream consumer for the FIFO_v buffer. It pops one DATA_W-bit word per frame through the FIFO's rd_en/data_out/empty interface and shifts it out MSB-first on a 3-wire SPI-style master link (sclk, sdo, cs_n). It handles the FIFO's 1-cycle read latency, detects read-on-empty via the FIFO err flag, and counts words transmitted.

Parameters:
DATA_W, 24, word width; must match the FIFO DATA_W.
CLK_DIV, 4, clk cycles per sclk half-period; minimum 1.
GAP_CYC, 2, minimum idle clk cycles with cs_n high after each frame; minimum 1.
CNT_W, 16, width of words_sent.

Ports:
clk  in  1  system clock; all logic on rising edge.
reset  in  1  asynchronous, active-high reset.
enable  in  1  permits new frames; sampled only in IDLE.
fifo_empty  in  1  FIFO empty flag.
fifo_data  in  DATA_W  FIFO data_out.
fifo_err  in  1  FIFO err flag.
clr_err  in  1  synchronous clear of underrun.
fifo_rd_en  out  1  FIFO read strobe, one clk per word.
sclk  out  1  serial clock, idles low.
sdo  out  1  serial data, MSB first.
cs_n  out  1  frame select, active low.
busy  out  1  high in any state other than IDLE.
done  out  1  one-clk pulse at the end of each completed frame.
underrun  out  1  sticky read-on-empty error.
words_sent  out  CNT_W  count of completed frames; wraps modulo 2^CNT_W.

Behaviour:
- Reset (asynchronous, active-high) forces: state=IDLE, fifo_rd_en=0, sclk=0, sdo=0, cs_n=1, busy=0, done=0, underrun=0, words_sent=0, shift register=0.
- All outputs are registered except fifo_rd_en and busy, which decode the state register.
- FSM states: IDLE, POP, LOAD, SHIFT, GAP.
- IDLE: if enable=1 and fifo_empty=0, next state is POP. Otherwise stay in IDLE.
- POP: lasts exactly 1 clk with fifo_rd_en=1, then LOAD.
- LOAD: lasts 1 clk.
  - If fifo_err=1: set underrun=1, keep cs_n=1, return to IDLE.
  - Otherwise, at the next edge: capture fifo_data into the shift register, set cs_n=0, drive sdo=fifo_data[DATA_W-1], then enter SHIFT.
- SHIFT: one bit per 2*CLK_DIV clks.
  - sclk is low for CLK_DIV clks, then high for CLK_DIV clks.
  - The receiver samples sdo on the sclk rising edge.
  - sdo advances to the next bit on the clk edge where sclk returns low.
  - A bit counter (width clog2(DATA_W+1)) counts to DATA_W.
  - After the high phase of the last bit: sclk=0, cs_n=1, done=1 for one clk, words_sent+1, enter GAP.
- GAP: holds for GAP_CYC clks with cs_n=1 and sdo=0, then IDLE.
- Timing: cs_n is low for exactly DATA_W*2*CLK_DIV clks. Minimum cs_n-high time between back-to-back frames is GAP_CYC+3 clks (GAP + IDLE + POP + LOAD).
- enable deasserted mid-frame: the current frame completes; no new POP.
- clr_err=1 clears underrun. If set and clear occur in the same cycle, set wins.
- fifo_empty changing during SHIFT/GAP is ignored; it is re-sampled only in IDLE.
- Reset mid-frame: cs_n and sclk go inactive immediately (asynchronously); the in-flight word is lost and is not counted.
- words_sent wraps from 2^CNT_W-1 to 0 without error.

Optional Feature:
FIFO_SPI_DRAIN_PARITY_EN:
- Defined: one even-parity bit (XOR of the word) is appended after the LSB as an extra sclk cycle. Frame length becomes (DATA_W+1)*2*CLK_DIV clks.
- Undefined: no parity bit; frame is exactly DATA_W bits; the parity logic is absent.

Test Plan:
(All scenarios use DATA_W=24, CLK_DIV=2, GAP_CYC=2, CNT_W=16, parity off unless stated.)
1. Assert reset for 3 clks, then release with fifo_empty=1 -> all outputs at reset values; fifo_rd_en never asserts over 100 clks.
2. Single word 0xA5C3F0, enable=1 -> one fifo_rd_en pulse; cs_n low for 96 clks; 24 sclk rising edges sample bits 1010_0101_1100_0011_1111_0000; done pulses once; words_sent=1.
3. Three words 0x000001, 0x800000, 0xFFFFFF queued -> three frames with correct bits; cs_n high for exactly 5 clks between frames; words_sent=3.
4. fifo_err=1 during the LOAD cycle -> underrun=1, cs_n stays 1, words_sent unchanged. clr_err pulse -> underrun=0. A subsequent valid word transmits normally.
5. Assert reset after 10 bits of 0x123456 -> cs_n=1 and sclk=0 within the same cycle. After release, with 0x654321 queued, a full fresh frame is sent; words_sent=1.
6. FIFO_SPI_DRAIN_PARITY_EN defined, word 0x000007 -> 25 sclk rising edges; 25th bit=1; cs_n low for 100 clks.
